// File: rtl/rdiv_share_arb.sv
// rdiv_share_arb: several requesters share one round-half-up power-of-two divider.
// A round-robin arbiter grants at most one requester per cycle. The granted
// dividend is divided by 2^DIV_LOG2, rounded half up and saturated, then held in a
// single output register together with the index of the requester that sent it.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (req_ready is one-hot or zero)
//   req_din               packed dividends; requester i is at [i*IN_WIDTH +: IN_WIDTH]
//   out_valid/out_ready   result handshake
//   out_dout, out_id      rounded quotient and the index of its requester
//   out_sat               the held result was clipped
//   sat_count             clipped results consumed since reset (saturating)
//   busy                  out_valid or any req_valid set
module rdiv_share_arb #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DIV_LOG2  = 3,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned IN_WIDTH  = OUT_WIDTH + DIV_LOG2,
    parameter int unsigned ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*IN_WIDTH-1:0] req_din,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_WIDTH-1:0]        out_dout,
    output logic [ID_WIDTH-1:0]         out_id,
    output logic                        out_sat,
    output logic [CNT_WIDTH-1:0]        sat_count,
    output logic                        busy
);

    localparam int unsigned SUM_WIDTH = OUT_WIDTH + 1;

    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] out_dout_q,  out_dout_d;
    logic [ID_WIDTH-1:0]  out_id_q,    out_id_d;
    logic                 out_sat_q,   out_sat_d;
    logic [CNT_WIDTH-1:0] sat_count_q, sat_count_d;
    logic [ID_WIDTH-1:0]  rr_ptr_q,    rr_ptr_d;

    logic                 slot_free;
    logic                 grant_any;
    logic                 found_hi;
    logic [ID_WIDTH-1:0]  idx_hi;
    logic [ID_WIDTH-1:0]  idx_lo;
    logic [ID_WIDTH-1:0]  grant_idx;
    logic [NUM_REQ-1:0]   grant;
    logic                 accept;

    logic [IN_WIDTH-1:0]  din_arr [NUM_REQ];
    logic [IN_WIDTH-1:0]  sel_din;
    logic [OUT_WIDTH-1:0] quo;
    logic                 rnd;
    logic [SUM_WIDTH-1:0] sum;
    logic [OUT_WIDTH-1:0] rdiv_res;
    logic                 rdiv_sat;
    logic                 unused_din_bits;

    // Unpack the flat dividend bus into one word per requester.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign din_arr[k] = req_din[k*IN_WIDTH +: IN_WIDTH];
    end

    assign slot_free = !out_valid_q || out_ready;

    // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid overall.
    always_comb begin
        found_hi = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                idx_lo = ID_WIDTH'(j);
            end
            if (req_valid[j] && (j >= int'(rr_ptr_q))) begin
                idx_hi   = ID_WIDTH'(j);
                found_hi = 1'b1;
            end
        end
        grant_any = |req_valid;
        grant_idx = found_hi ? idx_hi : idx_lo;
        grant     = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    assign accept    = slot_free && grant_any;
    assign req_ready = (slot_free && !reset) ? grant : '0;

    // Round half up: add the bit just below the quotient; clip on carry out.
    assign sel_din         = din_arr[grant_idx];
    assign quo             = sel_din[IN_WIDTH-1:DIV_LOG2];
    assign rnd             = sel_din[DIV_LOG2-1];
    assign sum             = {1'b0, quo} + SUM_WIDTH'(rnd);
    assign rdiv_sat        = sum[OUT_WIDTH];
    assign rdiv_res        = rdiv_sat ? quo : sum[OUT_WIDTH-1:0];
    // Bits below the rounding bit do not affect the result.
    assign unused_din_bits = ^sel_din;

    // Next-state: load on accept, drain on consume, count clipped results on consume.
    always_comb begin
        out_valid_d = out_valid_q;
        out_dout_d  = out_dout_q;
        out_id_d    = out_id_q;
        out_sat_d   = out_sat_q;
        sat_count_d = sat_count_q;
        rr_ptr_d    = rr_ptr_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_id_d    = grant_idx;
            out_dout_d  = rdiv_res;
            out_sat_d   = rdiv_sat;
            rr_ptr_d    = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                : grant_idx + ID_WIDTH'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (out_valid_q && out_ready && out_sat_q && (sat_count_q != '1)) begin
            sat_count_d = sat_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_dout_q  <= '0;
            out_id_q    <= '0;
            out_sat_q   <= 1'b0;
            sat_count_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_dout_q  <= out_dout_d;
            out_id_q    <= out_id_d;
            out_sat_q   <= out_sat_d;
            sat_count_q <= sat_count_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_dout  = out_dout_q;
    assign out_id    = out_id_q;
    assign out_sat   = out_sat_q;
    assign sat_count = sat_count_q;
    assign busy      = out_valid_q || (|req_valid);

endmodule

// File: tb/tb_rdiv_share_arb.sv
// Testbench for rdiv_share_arb: table of per-cycle vectors with hand-computed
// expectations, plus sequences for reset-mid-operation and a narrow sat counter.
module tb_rdiv_share_arb;

    localparam int unsigned NR   = 4;
    localparam int unsigned INW  = 35;
    localparam int unsigned NVEC = 20;

    localparam logic [34:0] DMAX   = 35'h7_FFFF_FFFF;
    localparam logic [34:0] DNEAR  = 35'h7_FFFF_FFF4;
    localparam logic [34:0] DQ1R0  = 35'h7_FFFF_FFFB;
    localparam logic [34:0] DZ     = 35'd0;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*INW-1:0] req_din;
    logic [NR-1:0]     req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_dout;
    logic [1:0]        out_id;
    logic              out_sat;
    logic [15:0]       sat_count;
    logic              busy;

    logic [NR-1:0]     s_valid;
    logic [NR*INW-1:0] s_din;
    logic [NR-1:0]     s_ready;
    logic              s_ovalid;
    logic              s_oready;
    logic [31:0]       s_dout;
    logic [1:0]        s_id;
    logic              s_sat;
    logic [1:0]        s_cnt;
    logic              s_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rdiv_share_arb dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_din   (req_din),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dout  (out_dout),
        .out_id    (out_id),
        .out_sat   (out_sat),
        .sat_count (sat_count),
        .busy      (busy)
    );

    rdiv_share_arb #(.CNT_WIDTH(2)) u_small (
        .clk       (clk),
        .reset     (reset),
        .req_valid (s_valid),
        .req_din   (s_din),
        .req_ready (s_ready),
        .out_valid (s_ovalid),
        .out_ready (s_oready),
        .out_dout  (s_dout),
        .out_id    (s_id),
        .out_sat   (s_sat),
        .sat_count (s_cnt),
        .busy      (s_busy)
    );

    typedef struct packed {
        logic [3:0]      valid;
        logic [4*35-1:0] din;
        logic            ordy;
        logic [3:0]      e_ready;
        logic            e_valid;
        logic [31:0]     e_dout;
        logic [1:0]      e_id;
        logic            e_sat;
        logic [15:0]     e_cnt;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [3:0] v, input logic [4*35-1:0] d,
                                input logic o, input logic [3:0] er, input logic ev,
                                input logic [31:0] ed, input logic [1:0] eid,
                                input logic es, input logic [15:0] ec);
        vec_t r;
        r.valid = v;  r.din = d;     r.ordy = o;
        r.e_ready = er; r.e_valid = ev; r.e_dout = ed;
        r.e_id = eid; r.e_sat = es;  r.e_cnt = ec;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [4*35-1:0] drr;
        logic            prev_valid;
        int              exp_cnt;

        drr = {35'd100, 35'd12, 35'd27, 35'd16};

        vecs[0]  = mk(4'b0001, {DZ, DZ, DZ, 35'd20}, 1'b1, 4'b0001, 1'b1, 32'd3, 2'd0, 1'b0, 16'd0);
        vecs[1]  = mk(4'b0001, {DZ, DZ, DZ, 35'd19}, 1'b1, 4'b0001, 1'b1, 32'd2, 2'd0, 1'b0, 16'd0);
        vecs[2]  = mk(4'b0001, {DZ, DZ, DZ, DMAX},   1'b1, 4'b0001, 1'b1, 32'hFFFF_FFFF, 2'd0, 1'b1, 16'd0);
        vecs[3]  = mk(4'b0000, {DZ, DZ, DZ, DZ},     1'b1, 4'b0000, 1'b0, 32'hFFFF_FFFF, 2'd0, 1'b1, 16'd1);
        vecs[4]  = mk(4'b0000, {DZ, DZ, DZ, DZ},     1'b0, 4'b0000, 1'b0, 32'hFFFF_FFFF, 2'd0, 1'b1, 16'd1);
        vecs[5]  = mk(4'b1111, drr, 1'b1, 4'b0010, 1'b1, 32'd3,  2'd1, 1'b0, 16'd1);
        vecs[6]  = mk(4'b1111, drr, 1'b1, 4'b0100, 1'b1, 32'd2,  2'd2, 1'b0, 16'd1);
        vecs[7]  = mk(4'b1111, drr, 1'b1, 4'b1000, 1'b1, 32'd13, 2'd3, 1'b0, 16'd1);
        vecs[8]  = mk(4'b1111, drr, 1'b1, 4'b0001, 1'b1, 32'd2,  2'd0, 1'b0, 16'd1);
        for (int i = 9; i < 14; i++) begin
            vecs[i] = mk(4'b1111, drr, 1'b0, 4'b0000, 1'b1, 32'd2, 2'd0, 1'b0, 16'd1);
        end
        vecs[14] = mk(4'b1111, drr, 1'b1, 4'b0010, 1'b1, 32'd3,  2'd1, 1'b0, 16'd1);
        vecs[15] = mk(4'b1010, drr, 1'b1, 4'b1000, 1'b1, 32'd13, 2'd3, 1'b0, 16'd1);
        vecs[16] = mk(4'b1010, drr, 1'b1, 4'b0010, 1'b1, 32'd3,  2'd1, 1'b0, 16'd1);
        vecs[17] = mk(4'b0000, drr, 1'b1, 4'b0000, 1'b0, 32'd3,  2'd1, 1'b0, 16'd1);
        vecs[18] = mk(4'b0100, {DZ, DNEAR, DZ, DZ}, 1'b1, 4'b0100, 1'b1, 32'hFFFF_FFFF, 2'd2, 1'b0, 16'd1);
        vecs[19] = mk(4'b1000, {DQ1R0, DZ, DZ, DZ}, 1'b1, 4'b1000, 1'b1, 32'hFFFF_FFFF, 2'd3, 1'b0, 16'd1);

        // Reset with requests present: ready must stay low, outputs cleared.
        reset     = 1'b1;
        req_valid = 4'b1111;
        req_din   = drr;
        out_ready = 1'b1;
        s_valid   = '0;
        s_din     = '0;
        s_oready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",  64'(req_ready), 64'd0);
        check("rst_valid",  64'(out_valid), 64'd0);
        check("rst_dout",   64'(out_dout),  64'd0);
        check("rst_id",     64'(out_id),    64'd0);
        check("rst_sat",    64'(out_sat),   64'd0);
        check("rst_cnt",    64'(sat_count), 64'd0);
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;
        prev_valid = 1'b0;

        for (int i = 0; i < int'(NVEC); i++) begin
            @(negedge clk);
            req_valid = vecs[i].valid;
            req_din   = vecs[i].din;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vecs[i].e_ready));
            check($sformatf("v%0d_busy", i),  64'(busy), 64'(prev_valid || (|vecs[i].valid)));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vecs[i].e_valid));
            check($sformatf("v%0d_dout", i),  64'(out_dout),  64'(vecs[i].e_dout));
            check($sformatf("v%0d_id", i),    64'(out_id),    64'(vecs[i].e_id));
            check($sformatf("v%0d_sat", i),   64'(out_sat),   64'(vecs[i].e_sat));
            check($sformatf("v%0d_cnt", i),   64'(sat_count), 64'(vecs[i].e_cnt));
            prev_valid = vecs[i].e_valid;
        end

        // Reset mid-operation with a held result and pending requests.
        @(negedge clk);
        req_valid = 4'b1111;
        req_din   = drr;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_hold_id", 64'(out_id), 64'd3);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_dout",  64'(out_dout),  64'd0);
        check("mid_rst_cnt",   64'(sat_count), 64'd0);
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 4'b1100;
        out_ready = 1'b1;
        #1;
        check("post_rst_ready", 64'(req_ready), 64'b0100);
        @(posedge clk);
        #1;
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_id",    64'(out_id),    64'd2);
        check("post_rst_dout",  64'(out_dout),  64'd2);

        // Two-bit sat counter: five clipped results stick the count at 3.
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            s_valid = (k <= 5) ? 4'b0001 : 4'b0000;
            s_din   = {DZ, DZ, DZ, DMAX};
            @(posedge clk);
            #1;
            exp_cnt = (k - 1 > 3) ? 3 : k - 1;
            check($sformatf("small_cnt%0d", k), 64'(s_cnt), 64'(exp_cnt));
            if (k <= 5) begin
                check($sformatf("small_sat%0d", k), 64'(s_sat), 64'd1);
            end
        end
        check("small_idle_valid", 64'(s_ovalid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rdiv_share_arb.md
Name: rdiv_share_arb

Overview:
- Shares one round-half-up power-of-two divider between NUM_REQ requesters.
- Each requester offers a din word over a valid/ready handshake.
- A round-robin arbiter picks one requester per cycle. Its word is divided by 2^DIV_LOG2, rounded half up and saturated, then held in a single output register tagged with the requester index.
- Sits between several producer channels and one downstream consumer. Keeps a saturating count of clipped results for debug.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DIV_LOG2, 3, divide shift amount (>=1).
- OUT_WIDTH, 32, quotient width.
- IN_WIDTH, OUT_WIDTH+DIV_LOG2, dividend width.
- ID_WIDTH, $clog2(NUM_REQ), requester tag width.
- CNT_WIDTH, 16, saturation-event counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester valid.
- req_din  input  NUM_REQ*IN_WIDTH  packed dividends; requester i occupies bits [i*IN_WIDTH +: IN_WIDTH].
- req_ready  output  NUM_REQ  per-requester ready; one-hot or zero.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_dout  output  OUT_WIDTH  rounded quotient.
- out_id  output  ID_WIDTH  index of the requester that produced out_dout.
- out_sat  output  1  the held result was clipped.
- sat_count  output  CNT_WIDTH  number of clipped results accepted since reset; sticks at max.
- busy  output  1  out_valid or any req_valid set.

Behaviour:
- Reset (reset=1 at a clk edge) forces:
  - out_valid=0, out_dout=0, out_id=0, out_sat=0.
  - sat_count=0, round-robin pointer rr_ptr=0.
  - req_ready=0 on the cycles reset is high.
- Reset mid-operation discards the held result. No handshake completes on a reset cycle.
- Slot free: slot_free = !out_valid || out_ready (combinational).
- Arbitration (combinational): among req_valid, the first set bit searching rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ.
  - Grant is one-hot, or zero when no req_valid is set.
  - req_ready = grant when slot_free, else 0.
  - req_ready never depends on req_din.
- Accept when slot_free and a grant exists. At the clk edge:
  - out_valid<=1, out_id<=granted index g.
  - out_dout<=rdiv(req_din[g]), out_sat<=sat flag.
  - rr_ptr<=(g+1) mod NUM_REQ.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 result per cycle while out_ready=1.
- No accept but out_valid and out_ready both set: out_valid<=0. out_dout, out_id and out_sat hold their values; rr_ptr holds.
- out_valid=1 with out_ready=0: all outputs stable, req_ready=0.
- Back-to-back case: out_ready=1 and a new grant in the same cycle → the old result leaves and the new result loads on the same edge.
- rdiv(x):
  - q = x[IN_WIDTH-1:DIV_LOG2] (OUT_WIDTH bits); r = x[DIV_LOG2-1].
  - Compute q+r at OUT_WIDTH+1 bits.
  - Carry out set → result = q (all ones), sat=1.
  - Otherwise result = q+r, sat=0.
  - Ties round up. Lower bits below r are ignored.
- sat_count increments by 1 on each edge where out_valid&&out_ready&&out_sat, i.e. counted on consumption, not on load. It saturates at 2^CNT_WIDTH-1.
- A requester that drops req_valid without a handshake is legal. The grant moves on with no state change.
- NUM_REQ=1 degenerates to a register slice: rr_ptr is constant 0.

Test Plan (defaults unless stated):
- Single requester 0, din=20, out_ready=1 → req_ready[0]=1 same cycle; next cycle out_valid=1, out_dout=3, out_id=0, out_sat=0. Also din=19 → out_dout=2.
- Saturation: din=35'h7_FFFF_FFFF → out_dout=32'hFFFF_FFFF, out_sat=1; sat_count becomes 1 only after out_ready handshake. With CNT_WIDTH=2, 5 such results → sat_count=3.
- Round-robin: all 4 req_valid held high, out_ready=1 → out_id sequence 0,1,2,3,0,1 over consecutive cycles, one result per cycle.
- Fairness after gaps: requesters 1 and 3 valid, rr_ptr=2 → grant 3 first, then 1.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 → req_ready=0 and outputs unchanged. On release, the old result is consumed and a new one loads on the same edge.
- Reset while out_valid=1 and requests pending → next cycle out_valid=0, sat_count=0, rr_ptr=0; first post-reset grant goes to the lowest valid index.
